// File: rtl/reg_file_sb_pkg.sv
// Shared constants for the register file and its write scoreboard.
package reg_file_sb_pkg;

    localparam int unsigned REG_NUM    = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned PEND_WIDTH = 2;

    localparam logic [DATA_WIDTH-1:0] ZERO_WORD     = '0;
    localparam logic [ADDR_WIDTH-1:0] ZERO_REG_ADDR = '0;

    typedef logic [PEND_WIDTH-1:0] pend_t;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register pending-write counters, RAW/full stall and sticky error flag.
module reg_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter int unsigned REG_NUM    = reg_file_sb_pkg::REG_NUM,
    parameter int unsigned ADDR_WIDTH = reg_file_sb_pkg::ADDR_WIDTH,
    parameter int unsigned PEND_WIDTH = reg_file_sb_pkg::PEND_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_en_1,
    input  logic [ADDR_WIDTH-1:0] read_addr_1,
    input  logic                  read_en_2,
    input  logic [ADDR_WIDTH-1:0] read_addr_2,
    input  logic                  issue_en,
    input  logic                  issue_write_en,
    input  logic [ADDR_WIDTH-1:0] issue_write_addr,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    output logic                  stall,
    output logic                  sb_err
);

    logic [PEND_WIDTH-1:0] cnt [REG_NUM];
    logic [REG_NUM-1:0]    fire;
    logic [REG_NUM-1:0]    retire;
    logic                  raw_1, raw_2, full, err_hit;

    // Hazard detection; a retiring last write releases the stall in the same cycle
    // because the read ports bypass the write-back data.
    always_comb begin
        raw_1 = read_en_1 && (read_addr_1 != '0) && (cnt[read_addr_1] != '0)
                && !(write_en && (write_addr == read_addr_1) && (cnt[read_addr_1] == PEND_WIDTH'(1)));
        raw_2 = read_en_2 && (read_addr_2 != '0) && (cnt[read_addr_2] != '0)
                && !(write_en && (write_addr == read_addr_2) && (cnt[read_addr_2] == PEND_WIDTH'(1)));
        full  = issue_write_en && (issue_write_addr != '0) && (cnt[issue_write_addr] == '1)
                && !(write_en && (write_addr == issue_write_addr));
        stall = !rst && (raw_1 || raw_2 || full);
        err_hit = write_en && (write_addr != '0) && (cnt[write_addr] == '0);
    end

    // Per-register issue (fire) and write-back (retire) strobes; index 0 never tracked.
    always_comb begin
        fire   = '0;
        retire = '0;
        for (int unsigned r = 1; r < REG_NUM; r++) begin
            fire[r]   = issue_en && !stall && issue_write_en && (issue_write_addr == ADDR_WIDTH'(r));
            retire[r] = write_en && (write_addr == ADDR_WIDTH'(r));
        end
    end

    // Counter update and sticky error capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < REG_NUM; r++) cnt[r] <= '0;
            sb_err <= 1'b0;
        end else begin
            for (int unsigned r = 1; r < REG_NUM; r++) begin
                if (fire[r] && !retire[r])
                    cnt[r] <= cnt[r] + PEND_WIDTH'(1);
                else if (retire[r] && !fire[r] && (cnt[r] != '0))
                    cnt[r] <= cnt[r] - PEND_WIDTH'(1);
            end
            if (err_hit) sb_err <= 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with WB->read bypass, $zero hardwired, plus pending-write scoreboard.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int unsigned REG_NUM    = reg_file_sb_pkg::REG_NUM,
    parameter int unsigned DATA_WIDTH = reg_file_sb_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = reg_file_sb_pkg::ADDR_WIDTH,
    parameter int unsigned PEND_WIDTH = reg_file_sb_pkg::PEND_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_en_1,
    input  logic [ADDR_WIDTH-1:0] read_addr_1,
    output logic [DATA_WIDTH-1:0] read_data_1,
    input  logic                  read_en_2,
    input  logic [ADDR_WIDTH-1:0] read_addr_2,
    output logic [DATA_WIDTH-1:0] read_data_2,
    input  logic                  issue_en,
    input  logic                  issue_write_en,
    input  logic [ADDR_WIDTH-1:0] issue_write_addr,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  stall,
    output logic                  sb_err
);

    logic [DATA_WIDTH-1:0] regs [REG_NUM];

    // Register storage; writes to index 0 are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < REG_NUM; r++) regs[r] <= '0;
        end else if (write_en && (write_addr != '0)) begin
            regs[write_addr] <= write_data;
        end
    end

    // Asynchronous read ports with same-cycle write-back bypass.
    always_comb begin
        read_data_1 = '0;
        read_data_2 = '0;
        if (!rst && read_en_1 && (read_addr_1 != '0))
            read_data_1 = (write_en && (write_addr == read_addr_1)) ? write_data : regs[read_addr_1];
        if (!rst && read_en_2 && (read_addr_2 != '0))
            read_data_2 = (write_en && (write_addr == read_addr_2)) ? write_data : regs[read_addr_2];
    end

    reg_scoreboard #(
        .REG_NUM    (REG_NUM),
        .ADDR_WIDTH (ADDR_WIDTH),
        .PEND_WIDTH (PEND_WIDTH)
    ) u_scoreboard (
        .clk              (clk),
        .rst              (rst),
        .read_en_1        (read_en_1),
        .read_addr_1      (read_addr_1),
        .read_en_2        (read_en_2),
        .read_addr_2      (read_addr_2),
        .issue_en         (issue_en),
        .issue_write_en   (issue_write_en),
        .issue_write_addr (issue_write_addr),
        .write_en         (write_en),
        .write_addr       (write_addr),
        .stall            (stall),
        .sb_err           (sb_err)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: expected outputs queued per step, compared mid-cycle.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read_en_1 = 1'b0, read_en_2 = 1'b0;
    logic [4:0]  read_addr_1 = '0, read_addr_2 = '0;
    logic [31:0] read_data_1, read_data_2;
    logic        issue_en = 1'b0, issue_write_en = 1'b0;
    logic [4:0]  issue_write_addr = '0;
    logic        write_en = 1'b0;
    logic [4:0]  write_addr = '0;
    logic [31:0] write_data = '0;
    logic        stall, sb_err;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        st;
        logic        se;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk              (clk),
        .rst              (rst),
        .read_en_1        (read_en_1),
        .read_addr_1      (read_addr_1),
        .read_data_1      (read_data_1),
        .read_en_2        (read_en_2),
        .read_addr_2      (read_addr_2),
        .read_data_2      (read_data_2),
        .issue_en         (issue_en),
        .issue_write_en   (issue_write_en),
        .issue_write_addr (issue_write_addr),
        .write_en         (write_en),
        .write_addr       (write_addr),
        .write_data       (write_data),
        .stall            (stall),
        .sb_err           (sb_err)
    );

    task automatic idle();
        read_en_1 = 1'b0; read_addr_1 = '0;
        read_en_2 = 1'b0; read_addr_2 = '0;
        issue_en = 1'b0; issue_write_en = 1'b0; issue_write_addr = '0;
        write_en = 1'b0; write_addr = '0; write_data = '0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        read_en_1 = (a1 != '0) || read_en_1; read_addr_1 = a1;
        read_en_2 = (a2 != '0) || read_en_2; read_addr_2 = a2;
    endtask

    task automatic iss(input logic [4:0] a);
        issue_en = 1'b1; issue_write_en = 1'b1; issue_write_addr = a;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        write_en = 1'b1; write_addr = a; write_data = d;
    endtask

    // Queue the expectation for the inputs just driven, check it mid-cycle, then advance.
    task automatic step(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                        input logic es, input logic ee);
        exp_t e;
        q.push_back('{tag, e1, e2, es, ee});
        #1;
        e = q.pop_front();
        vectors++;
        assert (read_data_1 === e.rd1) else begin
            miscompares++;
            $error("FAIL %s rd1 got %h exp %h", e.tag, read_data_1, e.rd1);
        end
        vectors++;
        assert (read_data_2 === e.rd2) else begin
            miscompares++;
            $error("FAIL %s rd2 got %h exp %h", e.tag, read_data_2, e.rd2);
        end
        vectors++;
        assert (stall === e.st) else begin
            miscompares++;
            $error("FAIL %s stall got %b exp %b", e.tag, stall, e.st);
        end
        vectors++;
        assert (sb_err === e.se) else begin
            miscompares++;
            $error("FAIL %s sb_err got %b exp %b", e.tag, sb_err, e.se);
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        // 1: reset state
        read_en_1 = 1'b1; read_en_2 = 1'b1; rd(5, 5);
        step("rst_hold", 0, 0, 0, 0);
        rst = 1'b0;
        read_en_1 = 1'b1; read_en_2 = 1'b1; rd(5, 5);
        step("t1_read_r5", 0, 0, 0, 0);

        // 2: write, stored read, bypass (r3 had no pending write -> sb_err sets)
        wb(3, 32'hDEADBEEF); rd(3, 0);
        step("t2_wb_r3_bypass", 32'hDEADBEEF, 0, 0, 0);
        wb(4, 32'h12345678); rd(3, 4);
        step("t2_r3_stored_r4_bypass", 32'hDEADBEEF, 32'h12345678, 0, 1);
        rd(0, 4);
        step("t2_r4_stored", 0, 32'h12345678, 0, 1);

        // 3: $zero
        wb(0, 32'hFFFFFFFF); read_en_1 = 1'b1; rd(0, 0);
        step("t3_wb_r0", 0, 0, 0, 1);
        read_en_1 = 1'b1; read_en_2 = 1'b1; rd(0, 0);
        step("t3_read_r0", 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            iss(0); read_en_2 = 1'b1; rd(0, 0);
            step("t3_issue_r0", 0, 0, 0, 1);
        end

        // 4: RAW on r7 released by the WB cycle itself
        iss(7);
        step("t4_issue_r7", 0, 0, 0, 1);
        rd(7, 0);
        step("t4_raw_r7_a", 0, 0, 1, 1);
        rd(7, 0);
        step("t4_raw_r7_b", 0, 0, 1, 1);
        wb(7, 32'h55); rd(7, 0);
        step("t4_wb_r7_release", 32'h55, 0, 0, 1);
        rd(7, 0);
        step("t4_r7_stored", 32'h55, 0, 0, 1);

        // 5: pending counter saturation on r9
        for (int i = 0; i < 3; i++) begin
            iss(9);
            step("t5_issue_r9", 0, 0, 0, 1);
        end
        iss(9);
        step("t5_full_r9", 0, 0, 1, 1);
        iss(9); wb(9, 32'h99);
        step("t5_full_with_wb", 0, 0, 0, 1);
        iss(9);
        step("t5_still_full", 0, 0, 1, 1);
        wb(9, 32'h91); rd(9, 0);
        step("t5_drain_cnt3", 32'h91, 0, 1, 1);
        wb(9, 32'h92); rd(9, 0);
        step("t5_drain_cnt2", 32'h92, 0, 1, 1);
        wb(9, 32'h93); rd(9, 0);
        step("t5_drain_cnt1", 32'h93, 0, 0, 1);
        rd(9, 0);
        step("t5_drained", 32'h93, 0, 0, 1);

        // 6: sticky error and reset mid-stall
        rst = 1'b1;
        step("t6_rst_a", 0, 0, 0, 1);
        rst = 1'b0; rd(3, 9);
        step("t6_regs_cleared", 0, 0, 0, 0);
        wb(11, 32'h1);
        step("t6_wb_r11_unpending", 0, 0, 0, 0);
        step("t6_err_set", 0, 0, 0, 1);
        step("t6_err_sticky", 0, 0, 0, 1);
        iss(7);
        step("t6_issue_r7_a", 0, 0, 0, 1);
        iss(7);
        step("t6_issue_r7_b", 0, 0, 0, 1);
        rd(7, 0);
        step("t6_raw_r7_cnt2", 0, 0, 1, 1);
        rst = 1'b1; rd(7, 11);
        step("t6_rst_mid_stall", 0, 0, 0, 1);
        rst = 1'b0; rd(7, 11);
        step("t6_after_rst", 0, 0, 0, 0);
        iss(7);
        step("t6_cnt7_cleared", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
